// File: rtl/cordic_linear_unit.sv
// Linear-mode CORDIC unit: signed multiply (rotation) or signed divide (vectoring)
// by shift-and-add, with a lower-part-OR approximate adder on the accumulator path.
module cordic_linear_unit #(
  parameter int DATA_W      = 8,
  parameter int ITER        = 12,
  parameter int APPROX_BITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [DATA_W-1:0]     in_x,
  input  logic [DATA_W-1:0]     in_z,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DATA_W-1:0]   out_result,
  output logic                  out_err
);

  localparam int ACC_W = DATA_W + ITER + 2;
  localparam int R_W   = ITER + 3;
  localparam int SH    = ITER - (DATA_W - 1);
  localparam int OUT_W = 2 * DATA_W;
  localparam int I_W   = $clog2(ITER + 1);

  localparam logic [I_W-1:0]   I_LAST  = I_W'(ITER - 1);
  localparam logic [I_W-1:0]   I_TOP   = I_W'(ITER);
  localparam logic [ACC_W-1:0] LO_MASK = ACC_W'((64'd1 << APPROX_BITS) - 64'd1);

  // Low field is a plain OR; the upper field is an exact sum that never sees a carry from below.
  function automatic logic [ACC_W-1:0] approx_add(input logic [ACC_W-1:0] a,
                                                  input logic [ACC_W-1:0] b);
    logic [ACC_W-1:0] lo;
    logic [ACC_W-1:0] hi;
    lo = (a | b) & LO_MASK;
    hi = (a & ~LO_MASK) + (b & ~LO_MASK);
    return hi | lo;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic               div0_q, div0_d;
  logic [I_W-1:0]     i_q, i_d;
  logic [ACC_W-1:0]   a_q, a_d;
  logic [ACC_W-1:0]   x_q, x_d;
  logic [R_W-1:0]     r_q, r_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_result_q, out_result_d;
  logic               out_err_q, out_err_d;

  logic [ACC_W-1:0]   x_load_s, z_acc_s, x_shift_s, addend_s, a_step_s;
  logic [R_W-1:0]     z_r_s, r_amt_s, r_step_s;
  logic [ACC_W-1:0]   r_ext_s;
  logic [OUT_W-1:0]   a_res_s, r_res_s;
  logic               d_pos_s, neg_s;

  // Operand loading and one CORDIC iteration step from the current registers.
  always_comb begin
    x_load_s  = {{(ACC_W-DATA_W){in_x[DATA_W-1]}}, in_x} << ITER;
    z_acc_s   = {{(ACC_W-DATA_W){in_z[DATA_W-1]}}, in_z} << ITER;
    z_r_s     = {{(R_W-DATA_W){in_z[DATA_W-1]}}, in_z} << SH;
    x_shift_s = ACC_W'($signed(x_q) >>> i_q);
    // Multiply steers on R's sign; divide drives A towards zero (A == 0 counts as non-negative).
    if (mode_q) begin
      d_pos_s = (a_q[ACC_W-1] == x_q[ACC_W-1]);
      neg_s   = d_pos_s;
    end else begin
      d_pos_s = ~r_q[R_W-1];
      neg_s   = ~d_pos_s;
    end
    if (neg_s) begin
      addend_s = {ACC_W{1'b0}} - x_shift_s;
    end else begin
      addend_s = x_shift_s;
    end
    a_step_s = approx_add(a_q, addend_s);
    r_amt_s  = {{(R_W-1){1'b0}}, 1'b1} << (I_TOP - i_q);
    if (neg_s) begin
      r_step_s = r_q + r_amt_s;
    end else begin
      r_step_s = r_q - r_amt_s;
    end
    r_ext_s = {{(ACC_W-R_W){r_step_s[R_W-1]}}, r_step_s};
    a_res_s = OUT_W'($signed(a_step_s) >>> SH);
    r_res_s = OUT_W'($signed(r_ext_s) >>> SH);
  end

  // Next-state and register update selection.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    div0_d       = div0_q;
    i_d          = i_q;
    a_d          = a_q;
    x_d          = x_q;
    r_d          = r_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_err_d    = out_err_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d    = RUN;
          mode_d     = in_mode;
          div0_d     = in_mode && (in_x == {DATA_W{1'b0}});
          i_d        = {I_W{1'b0}};
          x_d        = x_load_s;
          in_ready_d = 1'b0;
          if (in_mode) begin
            a_d = z_acc_s;
            r_d = {R_W{1'b0}};
          end else begin
            a_d = {ACC_W{1'b0}};
            r_d = z_r_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d = a_step_s;
        r_d = r_step_s;
        i_d = i_q + {{(I_W-1){1'b0}}, 1'b1};
        if (i_q == I_LAST) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_err_d   = div0_q;
          if (div0_q) begin
            out_result_d = {OUT_W{1'b0}};
          end else if (mode_q) begin
            out_result_d = r_res_s;
          end else begin
            out_result_d = a_res_s;
          end
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_err_d   = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_err_d   = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mode_q       <= 1'b0;
      div0_q       <= 1'b0;
      i_q          <= {I_W{1'b0}};
      a_q          <= {ACC_W{1'b0}};
      x_q          <= {ACC_W{1'b0}};
      r_q          <= {R_W{1'b0}};
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_result_q <= {OUT_W{1'b0}};
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      div0_q       <= div0_d;
      i_q          <= i_d;
      a_q          <= a_d;
      x_q          <= x_d;
      r_q          <= r_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_err_q    <= out_err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_err    = out_err_q;

endmodule

// File: tb/tb_cordic_linear_unit.sv
// Bench for cordic_linear_unit: exact (APPROX_BITS=0) and approximate (APPROX_BITS=3)
// instances share stimulus; a scoreboard holds golden-iteration results for both.
module tb_cordic_linear_unit;

  localparam int IT  = 12;
  localparam int ACC = 22;
  localparam int RW  = 15;
  localparam int SH  = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_mode = 1'b0;
  logic [7:0]  in_x = 8'd0;
  logic [7:0]  in_z = 8'd0;
  logic        out_ready = 1'b0;
  logic        in_ready0, in_ready3, out_valid0, out_valid3, out_err0, out_err3;
  logic [15:0] out_result0, out_result3;

  int checks = 0;
  int failures = 0;
  logic [15:0] last_res;

  typedef struct {
    logic [15:0] r0;
    logic [15:0] r3;
    logic        err;
    logic        mode;
    int          x;
    int          z;
  } exp_t;
  exp_t sb[$];

  cordic_linear_unit #(.DATA_W(8), .ITER(IT), .APPROX_BITS(0)) u_exact (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_mode(in_mode), .in_x(in_x), .in_z(in_z), .out_valid(out_valid0),
    .out_ready(out_ready), .out_result(out_result0), .out_err(out_err0));

  cordic_linear_unit #(.DATA_W(8), .ITER(IT), .APPROX_BITS(3)) u_approx (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
    .in_mode(in_mode), .in_x(in_x), .in_z(in_z), .out_valid(out_valid3),
    .out_ready(out_ready), .out_result(out_result3), .out_err(out_err3));

  always #5 clk = ~clk;

  function automatic longint wrapw(input longint v, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    v = v & m;
    if (((v >> (w - 1)) & 1) != 0) v = v - (longint'(1) << w);
    return v;
  endfunction

  function automatic longint aadd(input longint a, input longint b, input int ab);
    longint ua, ub, lo, hi;
    ua = a & ((longint'(1) << ACC) - 1);
    ub = b & ((longint'(1) << ACC) - 1);
    lo = (ua | ub) & ((longint'(1) << ab) - 1);
    hi = ((ua >> ab) + (ub >> ab)) << ab;
    return wrapw(hi | lo, ACC);
  endfunction

  // Golden iteration model written directly from the algorithm description.
  function automatic void model(input logic mode, input int x, input int z, input int ab,
                                output logic [15:0] res, output logic err);
    longint xa, a, r, xs, d, step, q;
    xa = wrapw(longint'(x) * (longint'(1) << IT), ACC);
    if (mode) begin
      a = wrapw(longint'(z) * (longint'(1) << IT), ACC);
      r = 0;
    end else begin
      a = 0;
      r = wrapw(longint'(z) * (longint'(1) << SH), RW);
    end
    for (int i = 0; i < IT; i++) begin
      xs = xa >>> i;
      step = longint'(1) << (IT - i);
      if (!mode) begin
        d = (r >= 0) ? 1 : -1;
        a = aadd(a, wrapw(d * xs, ACC), ab);
        r = wrapw(r - d * step, RW);
      end else begin
        d = ((a < 0) == (xa < 0)) ? 1 : -1;
        a = aadd(a, wrapw(-d * xs, ACC), ab);
        r = wrapw(r + d * step, RW);
      end
    end
    q = mode ? (r >>> SH) : (a >>> SH);
    if (mode && x == 0) q = 0;
    res = q[15:0];
    err = mode && (x == 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic mode, input int x, input int z);
    exp_t e;
    model(mode, x, z, 0, e.r0, e.err);
    model(mode, x, z, 3, e.r3, e.err);
    e.mode = mode;
    e.x = x;
    e.z = z;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic start_op(input logic mode, input int x, input int z);
    int n;
    n = 0;
    while (!in_ready0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", (n < 50), 1);
    push_exp(mode, x, z);
    in_mode = mode;
    in_x = x[7:0];
    in_z = z[7:0];
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_x = 8'($urandom);
    in_z = 8'($urandom);
    in_mode = 1'($urandom);
  endtask

  task automatic wait_result(input int lat0);
    int lat, ro, diff, ax;
    exp_t e;
    lat = lat0;
    while (!out_valid0 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, IT + 1);
    chk("valid_approx", out_valid3, 1);
    chk("sb_nonempty", (sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      last_res = out_result0;
      chk("res_exact", out_result0, e.r0);
      chk("res_approx", out_result3, e.r3);
      chk("err_exact", out_err0, e.err);
      chk("err_approx", out_err3, e.err);
      if (!e.mode) begin
        ro = int'($signed(out_result0));
        diff = ro - e.x * e.z;
        if (diff < 0) diff = -diff;
        ax = (e.x < 0) ? -e.x : e.x;
        chk("mul_tolerance", (16 * diff <= ax + 16), 1);
      end
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_in_ready", in_ready0, 1);
    chk("idle_out_valid", out_valid0, 0);
  endtask

  task automatic op(input logic mode, input int x, input int z);
    start_op(mode, x, z);
    wait_result(1);
    release_out();
  endtask

  initial begin
    int cx[8];
    int x, z, lim, ax;
    logic [15:0] held;
    logic stable;
    cx = '{-128, -127, -64, -1, 0, 1, 64, 127};

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready0, 1);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_out_result", out_result0, 0);
    chk("rst_out_err", out_err0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    op(1'b0, 100, 64);
    chk("mul_100_64_near", ((int'($signed(last_res)) >= 6393) && (int'($signed(last_res)) <= 6407)), 1);
    op(1'b0, -128, -128);
    chk("mul_m1_near", ((int'($signed(last_res)) >= 16375) && (int'($signed(last_res)) <= 16393)), 1);
    op(1'b1, 64, 32);
    chk("div_64_32", ((int'($signed(last_res)) >= 63) && (int'($signed(last_res)) <= 65)), 1);
    op(1'b1, 0, 5);
    chk("div0_result", last_res, 0);

    foreach (cx[i]) foreach (cx[j]) op(1'b0, cx[i], cx[j]);
    repeat (100) op(1'b0, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
    repeat (40) begin
      x = 0;
      while (x == 0) x = int'($urandom_range(0, 255)) - 128;
      ax = (x < 0) ? -x : x;
      lim = (2 * ax - 1 > 127) ? 127 : 2 * ax - 1;
      z = int'($urandom_range(0, 2 * lim)) - lim;
      op(1'b1, x, z);
    end

    // Backpressure followed by a back-to-back request.
    start_op(1'b0, -77, 93);
    wait_result(1);
    held = out_result0;
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_result0 !== held || out_valid0 !== 1'b1 || in_ready0 !== 1'b0) stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    push_exp(1'b0, 45, 99);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_mode = 1'b0;
    in_x = 8'd45;
    in_z = 8'd99;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_in_ready", in_ready0, 1);
    chk("b2b_out_valid", out_valid0, 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(1);
    release_out();

    // Asynchronous reset in the middle of RUN.
    start_op(1'b0, 55, -40);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready0, 1);
    chk("abort_out_valid", out_valid0, 0);
    chk("abort_out_result", out_result0, 0);
    chk("abort_out_err", out_err0, 0);
    if (sb.size() > 0) void'(sb.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // in_valid toggling during RUN must not disturb the operation.
    start_op(1'b0, 55, -40);
    repeat (3) begin
      in_valid = 1'b1;
      in_x = 8'($urandom);
      in_z = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_result(4);
    release_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
